// File: rtl/mips_muldiv.sv
// ---------------------------------------------------------------------------
// mips_muldiv
//
// Multi-cycle multiply/divide unit that owns the architectural HI/LO pair.
// Multiplies use radix-2 shift-add, divides use restoring shift-subtract.
// Both run on operand magnitudes, and the sign is fixed up in the last state.
// The unit also accepts mthi/mtlo moves while it is idle.
//
// Parameters:
//   WIDTH   operand width; HI and LO are each WIDTH bits (default 32)
//
// Ports:
//   clk     rising-edge clock
//   reset   synchronous, active-high; aborts any operation, clears HI/LO
//   start   operation request, sampled only while idle
//   op      00 multu, 01 mult, 10 divu, 11 div
//   src_a   multiplicand / dividend (rs), also the mthi/mtlo data
//   src_b   multiplier / divisor (rt)
//   mthi    write src_a to HI (idle only, dropped if start is high)
//   mtlo    write src_a to LO (idle only, dropped if start is high)
//   busy    operation in flight
//   done    one-cycle pulse when a mult/div result lands in HI/LO
//   hi, lo  HI / LO registers
//
// Optional feature macro: MIPS_MULDIV_FAST_MUL_EN
//   When defined, multiplies are computed combinationally in PREP and
//   retire straight from there (done one cycle after PREP). Divides keep
//   the iterative timing. When undefined, every op takes 35 cycles.
//
// State flow: IDLE -> PREP -> ITER (WIDTH cycles) -> FIX -> IDLE
// ---------------------------------------------------------------------------
module mips_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_ITER = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t state_reg, state_next;

    logic [CW-1:0]      cnt_reg;
    logic [1:0]         op_reg;       // bit 1: divide, bit 0: signed
    logic [WIDTH-1:0]   a_reg;        // |src_a| for signed ops, raw otherwise
    logic [WIDTH-1:0]   b_reg;        // |src_b| for signed ops, raw otherwise
    logic [WIDTH-1:0]   raw_a_reg;    // untouched dividend for divide-by-zero
    logic [2*WIDTH-1:0] acc_reg;      // mul: {partial, multiplier}; div: {rem, quot}
    logic               neg_q_reg;    // product / quotient must be negated
    logic               neg_r_reg;    // remainder must be negated
    logic [WIDTH-1:0]   hi_reg, lo_reg;
    logic               done_reg;

    // ------------------------------------------------------------------
    // Operand conditioning at start
    // ------------------------------------------------------------------
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] abs_a, abs_b;

    // The most negative value maps onto itself, and its unsigned reading
    // is the correct magnitude, so no extra bit is needed.
    assign a_neg = op[0] & src_a[WIDTH-1];
    assign b_neg = op[0] & src_b[WIDTH-1];
    assign abs_a = a_neg ? (~src_a + 1'b1) : src_a;
    assign abs_b = b_neg ? (~src_b + 1'b1) : src_b;

    // ------------------------------------------------------------------
    // One multiply step: add the multiplicand to the upper half when the
    // current multiplier bit is set, then shift the whole accumulator right.
    // The carry out of the add becomes the new top bit.
    // ------------------------------------------------------------------
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step;

    assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                    + (acc_reg[0] ? {1'b0, a_reg} : {(WIDTH+1){1'b0}});
    assign mul_step = {mul_sum, acc_reg[WIDTH-1:1]};

    // ------------------------------------------------------------------
    // One restoring divide step: shift the next dividend bit into the
    // remainder, and subtract the divisor if it fits. The quotient bit
    // enters the low end as the dividend bits leave it.
    // ------------------------------------------------------------------
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_fits;
    logic [2*WIDTH-1:0] div_step;

    assign div_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, b_reg};
    assign div_fits  = (div_shift >= {1'b0, b_reg});
    assign div_step  = {(div_fits ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                        acc_reg[WIDTH-2:0], div_fits};

    // ------------------------------------------------------------------
    // Sign correction and special cases applied in FIX
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]   fix_hi, fix_lo;
    logic [2*WIDTH-1:0] prod_signed;
    logic [WIDTH-1:0]   quot, rem;

    assign prod_signed = neg_q_reg ? (~acc_reg + 1'b1) : acc_reg;
    assign quot        = acc_reg[WIDTH-1:0];
    assign rem         = acc_reg[2*WIDTH-1:WIDTH];

    always_comb begin
        fix_hi = hi_reg;
        fix_lo = lo_reg;
        if (!op_reg[1]) begin
            fix_hi = prod_signed[2*WIDTH-1:WIDTH];
            fix_lo = prod_signed[WIDTH-1:0];
        end else if (b_reg == '0) begin
            // Divide by zero: LO saturates, HI keeps the dividend as given.
            fix_hi = raw_a_reg;
            fix_lo = '1;
        end else begin
            // Truncating division: quotient sign is the XOR of the operand
            // signs, and the remainder follows the dividend. The overflow case
            // 0x80000000 / -1 falls out naturally as 0x80000000 remainder 0.
            fix_lo = neg_q_reg ? (~quot + 1'b1) : quot;
            fix_hi = neg_r_reg ? (~rem + 1'b1) : rem;
        end
    end

`ifdef MIPS_MULDIV_FAST_MUL_EN
    // Single-cycle product of the latched magnitudes, sign-fixed the same way.
    logic [2*WIDTH-1:0] fast_prod;
    logic [2*WIDTH-1:0] fast_res;

    assign fast_prod = {{WIDTH{1'b0}}, a_reg} * {{WIDTH{1'b0}}, b_reg};
    assign fast_res  = neg_q_reg ? (~fast_prod + 1'b1) : fast_prod;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_PREP;
                end
            end
            S_PREP: begin
`ifdef MIPS_MULDIV_FAST_MUL_EN
                // Multiplies retire from PREP, so the result shows one
                // cycle after PREP.
                state_next = op_reg[1] ? S_ITER : S_IDLE;
`else
                state_next = S_ITER;
`endif
            end
            S_ITER: begin
                if (cnt_reg == CW'(WIDTH - 1)) begin
                    state_next = S_FIX;
                end
            end
            S_FIX: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            op_reg    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            raw_a_reg <= '0;
            acc_reg   <= '0;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        // start takes priority, so a move issued alongside
                        // it is dropped.
                        op_reg    <= op;
                        a_reg     <= abs_a;
                        b_reg     <= abs_b;
                        raw_a_reg <= src_a;
                        neg_q_reg <= a_neg ^ b_neg;
                        neg_r_reg <= a_neg;
                    end else begin
                        if (mthi) begin
                            hi_reg <= src_a;
                        end
                        if (mtlo) begin
                            lo_reg <= src_a;
                        end
                    end
                end
                S_PREP: begin
                    cnt_reg <= '0;
                    // Multiply keeps the multiplier in the low half and
                    // consumes it LSB first. Divide keeps the dividend there
                    // and consumes it MSB first.
                    acc_reg <= {{WIDTH{1'b0}}, (op_reg[1] ? a_reg : b_reg)};
`ifdef MIPS_MULDIV_FAST_MUL_EN
                    if (!op_reg[1]) begin
                        hi_reg   <= fast_res[2*WIDTH-1:WIDTH];
                        lo_reg   <= fast_res[WIDTH-1:0];
                        done_reg <= 1'b1;
                    end
`endif
                end
                S_ITER: begin
                    cnt_reg <= cnt_reg + CW'(1);
                    acc_reg <= op_reg[1] ? div_step : mul_step;
                end
                S_FIX: begin
                    hi_reg   <= fix_hi;
                    lo_reg   <= fix_lo;
                    done_reg <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (state_reg != S_IDLE);
    assign done = done_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: tb/tb_mips_muldiv.sv
// ---------------------------------------------------------------------------
// tb_mips_muldiv
//
// Directed bench for mips_muldiv. A table of {op, operands, expected HI/LO}
// records is applied one operation at a time. Each operation is checked for
// latency, results and a single-cycle done pulse. Hand-written sequences
// cover the following cases:
//   - mthi/mtlo moves
//   - start colliding with a move
//   - start and mthi arriving while busy
//   - reset in the middle of an operation
//   - back-to-back starts
// MIPS_MULDIV_FAST_MUL_EN selects the expected multiply latency.
// ---------------------------------------------------------------------------
module tb_mips_muldiv;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        mthi;
    logic        mtlo;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

    mips_muldiv #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    // Long-running op for the busy/reset sequences: it must stay iterative
    // in both builds.
`ifdef MIPS_MULDIV_FAST_MUL_EN
    localparam logic [1:0]  LONG_OP  = OP_DIV;    // -7 / 2
    localparam logic [31:0] LONG_HI  = 32'hFFFFFFFF;
    localparam logic [31:0] LONG_LO  = 32'hFFFFFFFD;
    localparam logic [1:0]  LONG_UOP = OP_DIVU;
`else
    localparam logic [1:0]  LONG_OP  = OP_MULT;   // -7 * 2 = -14
    localparam logic [31:0] LONG_HI  = 32'hFFFFFFFF;
    localparam logic [31:0] LONG_LO  = 32'hFFFFFFF2;
    localparam logic [1:0]  LONG_UOP = OP_MULTU;
`endif

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [1:0] o);
`ifdef MIPS_MULDIV_FAST_MUL_EN
        return o[1] ? 34 : 1;
`else
        return 34;
`endif
    endfunction

    // Issue one op at a negedge. Return the number of posedges after the
    // sampling edge until done is seen. Stop after 100 and report the count.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, output int lat);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        if (!done) begin
            check("busy_after_start", {63'd0, busy}, 64'd1);
        end
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int done_cnt;
        int hold_bad;

        vecs[0]  = '{"mult_m2x3",     OP_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1]  = '{"multu_m2x3",    OP_MULTU, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA};
        vecs[2]  = '{"div_m7d2",      OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{"divu_100d7",    OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
        vecs[4]  = '{"divu_by0",      OP_DIVU,  32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF};
        vecs[5]  = '{"div_ovf",       OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[6]  = '{"mult_min_x2",   OP_MULT,  32'h80000000, 32'd2,        32'hFFFFFFFF, 32'h00000000};
        vecs[7]  = '{"multu_6x7",     OP_MULTU, 32'd6,        32'd7,        32'd0,        32'd42};
        vecs[8]  = '{"div_7dm2",      OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
        vecs[9]  = '{"div_m7by0",     OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[10] = '{"mult_min_sq",   OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[11] = '{"multu_max_sq",  OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[12] = '{"divu_max_d1",   OP_DIVU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF};
        vecs[13] = '{"divu_small",    OP_DIVU,  32'd3,        32'd10,       32'd3,        32'd0};

        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        src_a = '0;
        src_b = '0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset_hi",   {32'd0, hi}, 64'd0);
        check("reset_lo",   {32'd0, lo}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        $display("reset hi=%h lo=%h busy=%0d done=%0d", hi, lo, busy, done);

        // ---- mthi / mtlo ------------------------------------------------
        mthi = 1'b1; src_a = 32'h11111111;
        @(negedge clk);
        mthi = 1'b0;
        check("mthi_hi", {32'd0, hi}, 64'h11111111);
        check("mthi_lo", {32'd0, lo}, 64'h0);
        check("mthi_no_done", {63'd0, done}, 64'd0);
        mtlo = 1'b1; src_a = 32'h22222222;
        @(negedge clk);
        mtlo = 1'b0;
        check("mtlo_lo", {32'd0, lo}, 64'h22222222);
        check("mtlo_hi", {32'd0, hi}, 64'h11111111);
        mthi = 1'b1; mtlo = 1'b1; src_a = 32'h33333333;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        check("mtboth_hi", {32'd0, hi}, 64'h33333333);
        check("mtboth_lo", {32'd0, lo}, 64'h33333333);
        $display("moves hi=%h lo=%h", hi, lo);

        // ---- start wins over a simultaneous move -------------------------
        start = 1'b1; op = OP_MULTU; src_a = 32'd6; src_b = 32'd7; mthi = 1'b1;
        @(negedge clk);
        start = 1'b0; mthi = 1'b0;
        check("collide_busy", {63'd0, busy}, 64'd1);
        check("collide_hi_kept", {32'd0, hi}, 64'h33333333);
        lat = 1;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("collide_done_seen", {63'd0, done}, 64'd1);
        check("collide_hi", {32'd0, hi}, 64'd0);
        check("collide_lo", {32'd0, lo}, 64'd42);
        $display("collide hi=%h lo=%h", hi, lo);

        // ---- table-driven vectors ---------------------------------------
        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
            check({vecs[i].name, "_lat"}, 64'(lat), 64'(exp_lat(vecs[i].op)));
            check({vecs[i].name, "_hi"}, {32'd0, hi}, {32'd0, vecs[i].hi});
            check({vecs[i].name, "_lo"}, {32'd0, lo}, {32'd0, vecs[i].lo});
            check({vecs[i].name, "_busy_at_done"}, {63'd0, busy}, 64'd0);
            $display("vec %s op=%0d a=%h b=%h lat=%0d hi=%h lo=%h",
                     vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, lat, hi, lo);
            @(negedge clk);
            check({vecs[i].name, "_done_pulse"}, {63'd0, done}, 64'd0);
        end

        // ---- start + mthi while busy are ignored ------------------------
        mthi = 1'b1; mtlo = 1'b1; src_a = 32'h55AA55AA;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        start = 1'b1; op = LONG_OP; src_a = 32'hFFFFFFF9; src_b = 32'd2;
        @(negedge clk);
        start = 1'b0;
        done_cnt = 0;
        hold_bad = 0;
        for (int c = 1; c <= 60; c++) begin
            if (c == 9) begin
                start = 1'b1; op = OP_DIV; mthi = 1'b1; src_a = 32'd5; src_b = 32'd1;
            end
            if (c == 10) begin
                start = 1'b0; mthi = 1'b0;
            end
            if (done) begin
                done_cnt++;
            end else if (done_cnt == 0 && (hi !== 32'h55AA55AA || lo !== 32'h55AA55AA)) begin
                hold_bad++;
            end
            if (done_cnt == 1 && done) begin
                check("ignore_hi", {32'd0, hi}, {32'd0, LONG_HI});
                check("ignore_lo", {32'd0, lo}, {32'd0, LONG_LO});
            end
            @(negedge clk);
        end
        check("ignore_hold", 64'(hold_bad), 64'd0);
        check("ignore_done_count", 64'(done_cnt), 64'd1);
        check("ignore_idle_after", {63'd0, busy}, 64'd0);
        $display("ignore done_cnt=%0d hold_bad=%0d hi=%h lo=%h", done_cnt, hold_bad, hi, lo);

        // ---- reset mid-operation ----------------------------------------
        start = 1'b1; op = LONG_UOP; src_a = 32'h0000FFFF; src_b = 32'h00010001;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        check("pre_reset_busy", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_busy", {63'd0, busy}, 64'd0);
        check("midreset_hi",   {32'd0, hi}, 64'd0);
        check("midreset_lo",   {32'd0, lo}, 64'd0);
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) done_cnt++;
            @(negedge clk);
        end
        check("midreset_no_done", 64'(done_cnt), 64'd0);
        run_op(OP_MULTU, 32'd6, 32'd7, lat);
        check("after_reset_lat", 64'(lat), 64'(exp_lat(OP_MULTU)));
        check("after_reset_hi", {32'd0, hi}, 64'd0);
        check("after_reset_lo", {32'd0, lo}, 64'd42);
        $display("midreset then multu 6x7 lat=%0d hi=%h lo=%h", lat, hi, lo);

        // ---- back-to-back start on the done cycle -----------------------
        run_op(OP_MULT, 32'h80000000, 32'd2, lat);
        check("b2b_first_lat", 64'(lat), 64'(exp_lat(OP_MULT)));
        check("b2b_first_hi", {32'd0, hi}, 64'hFFFFFFFF);
        check("b2b_first_lo", {32'd0, lo}, 64'h0);
        start = 1'b1; op = OP_DIVU; src_a = 32'd100; src_b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        check("b2b_accepted", {63'd0, busy}, 64'd1);
        lat = 0;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_second_lat", 64'(lat), 64'd34);
        check("b2b_second_hi", {32'd0, hi}, 64'd2);
        check("b2b_second_lo", {32'd0, lo}, 64'd14);
        $display("b2b second lat=%0d hi=%h lo=%h", lat, hi, lo);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
